// File: rtl/bcd_conv_pkg.sv
// Shared types and constants for the sequential binary-to-BCD converter.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package bcd_conv_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int BCD_BASE  = 10;
  localparam int BCD_DIG_W = 4;

  // Largest value representable in ndig decimal digits: 10^ndig - 1.
  function automatic logic [63:0] bcd_max_val(input int ndig);
    logic [63:0] v;
    v = 64'd1;
    for (int i = 0; i < ndig; i++) begin
      v = v * 64'(BCD_BASE);
    end
    return v - 64'd1;
  endfunction

endpackage

// File: rtl/bcd_conv_seq_div10_step.sv
// Combinational divide-by-10 step: q = x / 10, r = x % 10.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; the caller decides when to use the result.
// Ports: x (DATA_W) dividend; q (DATA_W) quotient; r (4) remainder 0..9.
module div10_step
  import bcd_conv_pkg::*;
#(
  parameter int DATA_W = 16
) (
  input  logic [DATA_W-1:0] x,
  output logic [DATA_W-1:0] q,
  output logic [3:0]        r
);

  localparam logic [DATA_W-1:0] TEN = DATA_W'(BCD_BASE);

  assign q = x / TEN;
  // Remainder is always below 10, so the low nibble holds it exactly.
  assign r = 4'(x % TEN);

endmodule

// File: rtl/bcd_conv_seq.sv
// Sequential binary-to-BCD converter; one decimal digit per clock through a shared div10 step.
// Latency: out_valid rises NDIG edges after the accept edge; one item in flight, no bypass.
// Backpressure: result held stable in DONE until out_ready; in_ready low from accept to handshake.
// Ports: clk/rst (sync, active-high); bin_in/in_valid/in_ready input handshake;
//        bcd_out/ovf/out_valid/out_ready output handshake (digit 0 at [3:0]); busy = converting.
// Option: define BCD_SAT_EN to clamp inputs above 10^NDIG-1 to all nines (ovf still set);
//         without it the low NDIG decimal digits are produced.
module bcd_conv_seq
  import bcd_conv_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int NDIG   = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [DATA_W-1:0]         bin_in,
  input  logic                      in_valid,
  output logic                      in_ready,
  output logic [BCD_DIG_W*NDIG-1:0] bcd_out,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic                      ovf,
  output logic                      busy
);

  localparam int          OUT_W   = BCD_DIG_W * NDIG;
  localparam int          CNT_W   = $clog2(NDIG + 1);
  localparam logic [63:0] MAX_VAL = bcd_max_val(NDIG);

  state_t              state_q,   state_d;
  logic [DATA_W-1:0]   work_q,    work_d;
  logic [CNT_W-1:0]    cnt_q,     cnt_d;
  logic [OUT_W-1:0]    bcd_q,     bcd_d;
  logic                ovf_q,     ovf_d;
  logic                in_rdy_q,  in_rdy_d;
  logic                out_vld_q, out_vld_d;
  logic                busy_q,    busy_d;

  logic [DATA_W-1:0]   step_q;
  logic [3:0]          step_r;
  logic                ovf_in;

  div10_step #(.DATA_W(DATA_W)) u_div10 (
    .x (work_q),
    .q (step_q),
    .r (step_r)
  );

  assign ovf_in = (64'(bin_in) > MAX_VAL);

  always_comb begin
    state_d = state_q;
    work_d  = work_q;
    cnt_d   = cnt_q;
    bcd_d   = bcd_q;
    ovf_d   = ovf_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
`ifdef BCD_SAT_EN
          // Overflow only happens when MAX_VAL fits in DATA_W, so the slice is exact.
          work_d = ovf_in ? MAX_VAL[DATA_W-1:0] : bin_in;
`else
          work_d = bin_in;
`endif
          ovf_d   = ovf_in;
          cnt_d   = '0;
          state_d = CONV;
        end
      end
      CONV: begin
        // Remainders enter at the top; after NDIG shifts the first one is at [3:0].
        bcd_d  = {step_r, bcd_q[OUT_W-1:BCD_DIG_W]};
        work_d = step_q;
        cnt_d  = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(NDIG - 1)) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    // Handshake/status outputs are registered decodes of the next state.
    in_rdy_d  = (state_d == IDLE);
    out_vld_d = (state_d == DONE);
    busy_d    = (state_d == CONV);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      work_q    <= '0;
      cnt_q     <= '0;
      bcd_q     <= '0;
      ovf_q     <= 1'b0;
      in_rdy_q  <= 1'b1;
      out_vld_q <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      work_q    <= work_d;
      cnt_q     <= cnt_d;
      bcd_q     <= bcd_d;
      ovf_q     <= ovf_d;
      in_rdy_q  <= in_rdy_d;
      out_vld_q <= out_vld_d;
      busy_q    <= busy_d;
    end
  end

  assign in_ready  = in_rdy_q;
  assign out_valid = out_vld_q;
  assign bcd_out   = bcd_q;
  assign ovf       = ovf_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_bcd_conv_seq.sv
// Testbench for bcd_conv_seq: directed vectors with literal expectations plus a
// decimal-arithmetic reference model checked by a scoreboard every output cycle.
module tb_bcd_conv_seq;

  localparam int DATA_W = 16;
  localparam int NDIG   = 4;
  localparam int MAXV   = 9999;

  logic              clk = 1'b0;
  logic              rst;
  logic [DATA_W-1:0] bin_in;
  logic              in_valid;
  logic              in_ready;
  logic [15:0]       bcd_out;
  logic              out_valid;
  logic              out_ready;
  logic              ovf;
  logic              busy;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [15:0] bcd;
    logic        ovf;
  } exp_t;

  exp_t exp_q[$];

  bcd_conv_seq #(.DATA_W(DATA_W), .NDIG(NDIG)) dut (
    .clk       (clk),
    .rst       (rst),
    .bin_in    (bin_in),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .bcd_out   (bcd_out),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .ovf       (ovf),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: decimal digits by plain arithmetic.
  function automatic exp_t model(input int unsigned v);
    exp_t e;
    int unsigned w;
    e.ovf = (v > MAXV);
    w = v;
`ifdef BCD_SAT_EN
    if (w > MAXV) w = MAXV;
`endif
    e.bcd = '0;
    for (int i = 0; i < NDIG; i++) begin
      e.bcd[4*i +: 4] = 4'(w % 10);
      w = w / 10;
    end
    return e;
  endfunction

  // Scoreboard: checks every cycle the result is presented, including stalls.
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
    end else begin
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          chk("out_valid_unexpected", 32'(out_valid), 32'd0);
        end else begin
          chk("model_bcd", 32'(bcd_out), 32'(exp_q[0].bcd));
          chk("model_ovf", 32'(ovf), 32'(exp_q[0].ovf));
          if (out_ready) void'(exp_q.pop_front());
        end
      end
      if (in_valid && in_ready) exp_q.push_back(model(32'(bin_in)));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Steps until out_valid, bounded; returns edges waited.
  task automatic wait_out(output int n);
    n = 0;
    while (!out_valid && n < 40) begin
      step();
      n++;
    end
    chk("wait_out_timeout", 32'(out_valid), 32'd1);
  endtask

  task automatic run_one(input string name, input logic [15:0] val,
                         input logic [15:0] exp_bcd, input logic exp_ovf);
    int n;
    out_ready = 1'b1;
    bin_in    = val;
    in_valid  = 1'b1;
    step();
    in_valid = 1'b0;
    wait_out(n);
    chk({name, "_lat"}, 32'(n), 32'd4);
    chk({name, "_bcd"}, 32'(bcd_out), 32'(exp_bcd));
    chk({name, "_ovf"}, 32'(ovf), 32'(exp_ovf));
    step();
    chk({name, "_in_ready"}, 32'(in_ready), 32'd1);
    chk({name, "_ov_fall"}, 32'(out_valid), 32'd0);
  endtask

  initial begin
    int n;
    logic [15:0] sat_exp;
    logic [15:0] vals [3];
    logic [15:0] outs [3];
    int t_rise [3];
    int idx, got, cyc;
    logic rdy, prev_ov;

    rst = 1'b1; bin_in = '0; in_valid = 1'b0; out_ready = 1'b0;
    step(); step();
    rst = 1'b0;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_bcd", 32'(bcd_out), 32'd0);
    chk("rst_ovf", 32'(ovf), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);

    // Reset mid-conversion.
    bin_in = 16'd4321; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    chk("conv_busy", 32'(busy), 32'd1);
    chk("conv_in_ready", 32'(in_ready), 32'd0);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("midrst_in_ready", 32'(in_ready), 32'd1);
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_bcd", 32'(bcd_out), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    for (int i = 0; i < 6; i++) step();
    chk("midrst_no_out", 32'(out_valid), 32'd0);

    // Basic conversion and boundaries.
    run_one("basic_1234", 16'd1234, 16'h1234, 1'b0);
    run_one("zero", 16'd0, 16'h0000, 1'b0);
    run_one("nine", 16'd9, 16'h0009, 1'b0);
    run_one("ten", 16'd10, 16'h0010, 1'b0);
    run_one("max9999", 16'd9999, 16'h9999, 1'b0);

    // Overflow.
`ifdef BCD_SAT_EN
    sat_exp = 16'h9999;
    run_one("ovf_65535", 16'd65535, sat_exp, 1'b1);
    run_one("ovf_12345", 16'd12345, sat_exp, 1'b1);
    run_one("ovf_10000", 16'd10000, sat_exp, 1'b1);
`else
    sat_exp = 16'h5535;
    run_one("ovf_65535", 16'd65535, sat_exp, 1'b1);
    run_one("ovf_12345", 16'd12345, 16'h2345, 1'b1);
    run_one("ovf_10000", 16'd10000, 16'h0000, 1'b1);
`endif

    // Backpressure: stall in DONE while a new input waits.
    out_ready = 1'b0;
    bin_in = 16'd2024; in_valid = 1'b1;
    step();
    bin_in = 16'd77;
    wait_out(n);
    for (int i = 0; i < 10; i++) begin
      chk("bp_bcd", 32'(bcd_out), 32'h2024);
      chk("bp_in_ready", 32'(in_ready), 32'd0);
      chk("bp_out_valid", 32'(out_valid), 32'd1);
      step();
    end
    out_ready = 1'b1;
    step();
    chk("bp_post_hs_ready", 32'(in_ready), 32'd1);
    chk("bp_post_hs_ov", 32'(out_valid), 32'd0);
    step();
    in_valid = 1'b0;
    chk("bp_77_accepted", 32'(busy), 32'd1);
    wait_out(n);
    chk("bp_77_bcd", 32'(bcd_out), 32'h0077);
    step();

    // Back-to-back stream.
    vals[0] = 16'd100; vals[1] = 16'd5000; vals[2] = 16'd42;
    idx = 0; got = 0; cyc = 0; prev_ov = 1'b0;
    out_ready = 1'b1;
    bin_in = vals[0]; in_valid = 1'b1;
    while (got < 3 && cyc < 100) begin
      rdy = in_ready;
      step();
      cyc++;
      if (rdy && in_valid) begin
        idx++;
        if (idx < 3) bin_in = vals[idx];
        else in_valid = 1'b0;
      end
      if (out_valid && !prev_ov) begin
        outs[got] = bcd_out;
        t_rise[got] = cyc;
        got++;
      end
      prev_ov = out_valid;
    end
    chk("b2b_count", 32'(got), 32'd3);
    if (got == 3) begin
      chk("b2b_out0", 32'(outs[0]), 32'h0100);
      chk("b2b_out1", 32'(outs[1]), 32'h5000);
      chk("b2b_out2", 32'(outs[2]), 32'h0042);
      chk("b2b_gap01", 32'(t_rise[1] - t_rise[0]), 32'd6);
      chk("b2b_gap12", 32'(t_rise[2] - t_rise[1]), 32'd6);
    end
    step(); step();
    chk("sb_drain", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
